// File: rtl/kmp_partition_ctrl.sv
// Dispatch/collect controller for the parallel KMP matcher: splits the string into
// overlapping per-PE windows, gathers per-PE match reports and reduces them to the earliest hit.
module kmp_partition_ctrl #(
    parameter int NUM_PE = 4,
    parameter int STR_AW = 6,
    parameter int PAT_AW = 4,
    parameter int TO_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     input_valid,
    output logic                     input_ready,
    input  logic [STR_AW-1:0]        str_last_idx,
    input  logic [PAT_AW-1:0]        pat_last_idx,
    output logic                     pe_valid,
    output logic [NUM_PE-1:0]        pe_enable,
    output logic [NUM_PE*STR_AW-1:0] start_idx,
    output logic [NUM_PE*STR_AW-1:0] end_idx,
    input  logic [NUM_PE-1:0]        i_match_valid,
    input  logic [NUM_PE-1:0]        i_match,
    input  logic [NUM_PE*STR_AW-1:0] i_match_idx,
    output logic                     o_valid,
    output logic                     o_match,
    output logic [STR_AW-1:0]        o_match_idx,
    output logic                     o_timeout
);

    localparam int LOG2_PE = $clog2(NUM_PE);
    localparam logic [TO_W-1:0] WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_WAIT, S_REDUCE} state_t;
    typedef logic [STR_AW:0] ext_t;

    state_t                     state;
    logic [NUM_PE-1:0]          collected;
    logic [NUM_PE-1:0]          match_q;
    logic [NUM_PE*STR_AW-1:0]   idx_q;
    logic [TO_W-1:0]            wd;

    ext_t                       disp_len;
    ext_t                       disp_np;
    ext_t                       disp_raw;
    logic [NUM_PE-1:0]          disp_enable;
    logic [NUM_PE*STR_AW-1:0]   disp_start;
    logic [NUM_PE*STR_AW-1:0]   disp_end;

    logic [NUM_PE-1:0]          new_hits;
    logic                       all_in;
    logic                       red_hit;
    logic [STR_AW-1:0]          red_idx;

    // Window split, computed from the live request so it can be registered on the accept edge.
    // The length and window-end sums carry one extra bit so a full-width string cannot wrap.
    always_comb begin
        disp_len    = ext_t'(str_last_idx) + ext_t'(1);
        disp_np     = disp_len >> LOG2_PE;
        disp_raw    = '0;
        disp_enable = '0;
        disp_start  = '0;
        disp_end    = '0;
        if (disp_np == '0) begin
            disp_enable[0]          = 1'b1;
            disp_end[0 +: STR_AW]   = str_last_idx;
        end else begin
            disp_enable = '1;
            for (int k = 0; k < NUM_PE; k++) begin
                disp_start[k*STR_AW +: STR_AW] = STR_AW'(ext_t'(k) * disp_np);
                if (k == NUM_PE - 1) begin
                    disp_end[k*STR_AW +: STR_AW] = str_last_idx;
                end else begin
                    disp_raw = ext_t'(k + 1) * disp_np - ext_t'(1) + ext_t'(pat_last_idx);
                    disp_end[k*STR_AW +: STR_AW] =
                        (disp_raw > ext_t'(str_last_idx)) ? str_last_idx : STR_AW'(disp_raw);
                end
            end
        end
    end

    assign new_hits = i_match_valid & pe_enable & ~collected;
    assign all_in   = ((collected | new_hits) == pe_enable);

    // Strict '<' while scanning upward keeps ties on the lowest PE index.
    always_comb begin
        red_hit = 1'b0;
        red_idx = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            if (collected[k] && match_q[k] &&
                (!red_hit || idx_q[k*STR_AW +: STR_AW] < red_idx)) begin
                red_hit = 1'b1;
                red_idx = idx_q[k*STR_AW +: STR_AW];
            end
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            input_ready <= 1'b1;
            pe_valid    <= 1'b0;
            pe_enable   <= '0;
            start_idx   <= '0;
            end_idx     <= '0;
            // NOTE: the collect registers are reset as well so a stale result can never leak into a new job.
            collected   <= '0;
            match_q     <= '0;
            idx_q       <= '0;
            wd          <= '0;
            o_valid     <= 1'b0;
            o_match     <= 1'b0;
            o_match_idx <= '0;
            o_timeout   <= 1'b0;
        end else begin
            pe_valid <= 1'b0;
            o_valid  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (input_valid && input_ready) begin
                        state       <= S_DISPATCH;
                        input_ready <= 1'b0;
                        pe_valid    <= 1'b1;
                        pe_enable   <= disp_enable;
                        start_idx   <= disp_start;
                        end_idx     <= disp_end;
                    end
                end
                S_DISPATCH: begin
                    start_idx <= '0;
                    end_idx   <= '0;
                    collected <= '0;
                    match_q   <= '0;
                    idx_q     <= '0;
                    wd        <= '0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    wd <= wd + TO_W'(1);
                    for (int k = 0; k < NUM_PE; k++) begin
                        if (new_hits[k]) begin
                            collected[k]                <= 1'b1;
                            match_q[k]                  <= i_match[k];
                            idx_q[k*STR_AW +: STR_AW]   <= i_match_idx[k*STR_AW +: STR_AW];
                        end
                    end
                    if (all_in || wd == WD_LAST) begin
                        state <= S_REDUCE;
                    end
                end
                S_REDUCE: begin
                    o_valid     <= 1'b1;
                    o_match     <= red_hit;
                    o_match_idx <= red_idx;
                    o_timeout   <= (collected != pe_enable);
                    pe_enable   <= '0;
                    input_ready <= 1'b1;
                    state       <= S_IDLE;
                end
                default: begin
                    state       <= S_IDLE;
                    input_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kmp_partition_ctrl.sv
// Directed bench for kmp_partition_ctrl: window split, out-of-order collect, filtering,
// watchdog timeout, back-to-back jobs and reset abort, with hand-computed expectations.
module tb_kmp_partition_ctrl;

    localparam int NUM_PE = 4;
    localparam int STR_AW = 6;
    localparam int PAT_AW = 4;
    localparam int TO_W   = 4;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     input_valid;
    logic                     input_ready;
    logic [STR_AW-1:0]        str_last_idx;
    logic [PAT_AW-1:0]        pat_last_idx;
    logic                     pe_valid;
    logic [NUM_PE-1:0]        pe_enable;
    logic [NUM_PE*STR_AW-1:0] start_idx;
    logic [NUM_PE*STR_AW-1:0] end_idx;
    logic [NUM_PE-1:0]        i_match_valid;
    logic [NUM_PE-1:0]        i_match;
    logic [NUM_PE*STR_AW-1:0] i_match_idx;
    logic                     o_valid;
    logic                     o_match;
    logic [STR_AW-1:0]        o_match_idx;
    logic                     o_timeout;

    kmp_partition_ctrl #(
        .NUM_PE(NUM_PE), .STR_AW(STR_AW), .PAT_AW(PAT_AW), .TO_W(TO_W)
    ) dut (
        .clk(clk), .reset(reset),
        .input_valid(input_valid), .input_ready(input_ready),
        .str_last_idx(str_last_idx), .pat_last_idx(pat_last_idx),
        .pe_valid(pe_valid), .pe_enable(pe_enable),
        .start_idx(start_idx), .end_idx(end_idx),
        .i_match_valid(i_match_valid), .i_match(i_match), .i_match_idx(i_match_idx),
        .o_valid(o_valid), .o_match(o_match), .o_match_idx(o_match_idx), .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                       cyc;
        logic [NUM_PE-1:0]        v;
        logic [NUM_PE-1:0]        m;
        logic [NUM_PE*STR_AW-1:0] idx;
    } ev_t;

    int  tests = 0;
    int  fails = 0;
    int  cyc   = 0;
    ev_t sched[$];

    int                pulses;
    int                first_cyc;
    logic              cap_match;
    logic              cap_timeout;
    logic              cap_ready;
    logic [STR_AW-1:0] cap_idx;

    function automatic logic [NUM_PE*STR_AW-1:0] pack4(input int a0, input int a1,
                                                       input int a2, input int a3);
        return {STR_AW'(a3), STR_AW'(a2), STR_AW'(a1), STR_AW'(a0)};
    endfunction

    // Advance to just after the next rising edge; outputs are stable there.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Cycle 0 is the accept cycle; on return the bench sits in cycle 1 (DISPATCH).
    task automatic start_job(input int s, input int p);
        str_last_idx = STR_AW'(s);
        pat_last_idx = PAT_AW'(p);
        input_valid  = 1'b1;
        cyc          = 0;
        tick();
        input_valid  = 1'b0;
    endtask

    // Replays the queued result strobes by cycle number and records o_valid pulses until last_cyc.
    task automatic run_sched(input int last_cyc);
        logic [NUM_PE-1:0]        v;
        logic [NUM_PE-1:0]        m;
        logic [NUM_PE*STR_AW-1:0] ix;
        pulses    = 0;
        first_cyc = -1;
        while (cyc < last_cyc) begin
            if (o_valid) begin
                pulses++;
                if (first_cyc < 0) begin
                    first_cyc   = cyc;
                    cap_match   = o_match;
                    cap_idx     = o_match_idx;
                    cap_timeout = o_timeout;
                    cap_ready   = input_ready;
                end
            end
            v = '0; m = '0; ix = '0;
            foreach (sched[i]) begin
                if (sched[i].cyc == cyc) begin
                    v  = v | sched[i].v;
                    m  = m | sched[i].m;
                    ix = ix | sched[i].idx;
                end
            end
            i_match_valid = v;
            i_match       = m;
            i_match_idx   = ix;
            tick();
        end
        i_match_valid = '0;
        i_match       = '0;
        i_match_idx   = '0;
        sched.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tests++; if (input_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", input_ready); end
        tests++; if (pe_valid !== 1'b0) begin fails++; $display("FAIL rst_pe_valid: got %b want 0", pe_valid); end
        tests++; if (pe_enable !== 4'b0000) begin fails++; $display("FAIL rst_pe_enable: got %b want 0000", pe_enable); end
        tests++; if (start_idx !== '0 || end_idx !== '0) begin fails++; $display("FAIL rst_ranges: got %h/%h want 0/0", start_idx, end_idx); end
        tests++; if ({o_valid, o_match, o_timeout} !== 3'b000 || o_match_idx !== '0) begin
            fails++; $display("FAIL rst_outputs: got v%b m%b t%b idx%0d want all 0", o_valid, o_match, o_timeout, o_match_idx);
        end
    endtask

    task automatic test_dispatch();
        start_job(31, 3);
        tests++; if (pe_valid !== 1'b1) begin fails++; $display("FAIL disp_pe_valid: got %b want 1", pe_valid); end
        tests++; if (pe_enable !== 4'b1111) begin fails++; $display("FAIL disp_enable: got %b want 1111", pe_enable); end
        tests++; if (start_idx !== pack4(0, 8, 16, 24)) begin fails++; $display("FAIL disp_start: got %h want %h", start_idx, pack4(0, 8, 16, 24)); end
        tests++; if (end_idx !== pack4(10, 18, 26, 31)) begin fails++; $display("FAIL disp_end: got %h want %h", end_idx, pack4(10, 18, 26, 31)); end
        tests++; if (input_ready !== 1'b0) begin fails++; $display("FAIL disp_ready: got %b want 0", input_ready); end
        tick();
        tests++; if (pe_valid !== 1'b0 || start_idx !== '0 || end_idx !== '0) begin
            fails++; $display("FAIL disp_after: got pv%b %h/%h want 0/0/0", pe_valid, start_idx, end_idx);
        end
        tests++; if (pe_enable !== 4'b1111) begin fails++; $display("FAIL disp_enable_hold: got %b want 1111", pe_enable); end
        // All four report "no match" together in cycle 2: minimum latency path.
        sched.push_back('{2, 4'b1111, 4'b0000, pack4(0, 0, 0, 0)});
        run_sched(7);
        tests++; if (first_cyc !== 4 || pulses !== 1) begin fails++; $display("FAIL disp_latency: got cyc %0d pulses %0d want 4/1", first_cyc, pulses); end
        tests++; if (cap_match !== 1'b0 || cap_idx !== '0 || cap_timeout !== 1'b0) begin
            fails++; $display("FAIL disp_result: got m%b idx%0d t%b want 0/0/0", cap_match, cap_idx, cap_timeout);
        end
    endtask

    task automatic test_out_of_order();
        start_job(33, 2);
        tests++; if (end_idx !== pack4(9, 17, 25, 33)) begin fails++; $display("FAIL ooo_end: got %h want %h", end_idx, pack4(9, 17, 25, 33)); end
        sched.push_back('{5, 4'b1000, 4'b1000, pack4(0, 0, 0, 30)});
        sched.push_back('{7, 4'b0100, 4'b0100, pack4(0, 0, 17, 0)});
        sched.push_back('{9, 4'b0011, 4'b0000, pack4(0, 0, 0, 0)});
        run_sched(14);
        tests++; if (first_cyc !== 11 || pulses !== 1) begin fails++; $display("FAIL ooo_latency: got cyc %0d pulses %0d want 11/1", first_cyc, pulses); end
        tests++; if (cap_match !== 1'b1 || cap_idx !== 6'd17 || cap_timeout !== 1'b0) begin
            fails++; $display("FAIL ooo_result: got m%b idx%0d t%b want 1/17/0", cap_match, cap_idx, cap_timeout);
        end
        tests++; if (o_match !== 1'b1 || o_match_idx !== 6'd17) begin fails++; $display("FAIL ooo_hold: got m%b idx%0d want 1/17", o_match, o_match_idx); end
    endtask

    task automatic test_short_string();
        start_job(2, 1);
        tests++; if (pe_enable !== 4'b0001) begin fails++; $display("FAIL short_enable: got %b want 0001", pe_enable); end
        tests++; if (start_idx !== '0 || end_idx !== pack4(2, 0, 0, 0)) begin
            fails++; $display("FAIL short_ranges: got %h/%h want 0/%h", start_idx, end_idx, pack4(2, 0, 0, 0));
        end
        // PE2 is disabled; its strobe must not count as a match.
        sched.push_back('{2, 4'b0100, 4'b0100, pack4(0, 0, 1, 0)});
        sched.push_back('{4, 4'b0001, 4'b0000, pack4(0, 0, 0, 0)});
        run_sched(9);
        tests++; if (first_cyc !== 6 || pulses !== 1) begin fails++; $display("FAIL short_latency: got cyc %0d pulses %0d want 6/1", first_cyc, pulses); end
        tests++; if (cap_match !== 1'b0 || cap_idx !== '0 || cap_timeout !== 1'b0) begin
            fails++; $display("FAIL short_result: got m%b idx%0d t%b want 0/0/0", cap_match, cap_idx, cap_timeout);
        end
    endtask

    task automatic test_duplicates();
        start_job(31, 3);
        sched.push_back('{3, 4'b0110, 4'b0110, pack4(0, 12, 12, 0)});
        sched.push_back('{4, 4'b0010, 4'b0010, pack4(0, 5, 0, 0)});
        sched.push_back('{5, 4'b1001, 4'b0000, pack4(0, 0, 0, 0)});
        run_sched(12);
        tests++; if (pulses !== 1 || first_cyc !== 7) begin fails++; $display("FAIL dup_pulses: got cyc %0d pulses %0d want 7/1", first_cyc, pulses); end
        tests++; if (cap_match !== 1'b1 || cap_idx !== 6'd12 || cap_timeout !== 1'b0) begin
            fails++; $display("FAIL dup_result: got m%b idx%0d t%b want 1/12/0", cap_match, cap_idx, cap_timeout);
        end
    endtask

    task automatic test_timeout();
        start_job(31, 3);
        sched.push_back('{2, 4'b0001, 4'b0001, pack4(9, 0, 0, 0)});
        sched.push_back('{3, 4'b1100, 4'b1000, pack4(0, 0, 0, 28)});
        run_sched(22);
        tests++; if (first_cyc !== 18 || pulses !== 1) begin fails++; $display("FAIL to_latency: got cyc %0d pulses %0d want 18/1", first_cyc, pulses); end
        tests++; if (cap_timeout !== 1'b1) begin fails++; $display("FAIL to_flag: got %b want 1", cap_timeout); end
        tests++; if (cap_match !== 1'b1 || cap_idx !== 6'd9) begin fails++; $display("FAIL to_result: got m%b idx%0d want 1/9", cap_match, cap_idx); end
        tests++; if (cap_ready !== 1'b1) begin fails++; $display("FAIL to_ready: got %b want 1", cap_ready); end
    endtask

    task automatic test_back_to_back();
        start_job(31, 3);
        tick();
        i_match_valid = 4'b1111;
        i_match       = 4'b1000;
        i_match_idx   = pack4(0, 0, 0, 27);
        tick();
        i_match_valid = '0;
        i_match       = '0;
        i_match_idx   = '0;
        tick();
        tests++; if (o_valid !== 1'b1 || input_ready !== 1'b1 || o_match_idx !== 6'd27) begin
            fails++; $display("FAIL b2b_first: got v%b rdy%b idx%0d want 1/1/27", o_valid, input_ready, o_match_idx);
        end
        start_job(7, 1);
        tests++; if (pe_valid !== 1'b1 || pe_enable !== 4'b1111) begin
            fails++; $display("FAIL b2b_accept: got pv%b en%b want 1/1111", pe_valid, pe_enable);
        end
        tests++; if (start_idx !== pack4(0, 2, 4, 6) || end_idx !== pack4(2, 4, 6, 7)) begin
            fails++; $display("FAIL b2b_ranges: got %h/%h want %h/%h", start_idx, end_idx, pack4(0, 2, 4, 6), pack4(2, 4, 6, 7));
        end
        tests++; if (o_match !== 1'b1 || o_match_idx !== 6'd27 || o_valid !== 1'b0) begin
            fails++; $display("FAIL b2b_hold: got v%b m%b idx%0d want 0/1/27", o_valid, o_match, o_match_idx);
        end
        sched.push_back('{2, 4'b1111, 4'b0000, pack4(0, 0, 0, 0)});
        run_sched(8);
        tests++; if (first_cyc !== 4 || cap_match !== 1'b0 || cap_idx !== '0) begin
            fails++; $display("FAIL b2b_second: got cyc %0d m%b idx%0d want 4/0/0", first_cyc, cap_match, cap_idx);
        end
    endtask

    task automatic test_reset_abort();
        start_job(31, 3);
        tick();
        i_match_valid = 4'b0001;
        i_match       = 4'b0001;
        i_match_idx   = pack4(4, 0, 0, 0);
        tick();
        i_match_valid = '0;
        i_match       = '0;
        i_match_idx   = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++; if (input_ready !== 1'b1 || pe_enable !== 4'b0000 || pe_valid !== 1'b0) begin
            fails++; $display("FAIL abort_idle: got rdy%b en%b pv%b want 1/0000/0", input_ready, pe_enable, pe_valid);
        end
        tests++; if (o_valid !== 1'b0 || o_match !== 1'b0) begin fails++; $display("FAIL abort_out: got v%b m%b want 0/0", o_valid, o_match); end
        // Late strobes from the aborted job arrive while idle.
        cyc = 0;
        sched.push_back('{0, 4'b1110, 4'b1110, pack4(0, 1, 2, 3)});
        sched.push_back('{1, 4'b1110, 4'b1110, pack4(0, 1, 2, 3)});
        run_sched(5);
        tests++; if (pulses !== 0) begin fails++; $display("FAIL abort_no_valid: got %0d pulses want 0", pulses); end
        start_job(31, 3);
        sched.push_back('{2, 4'b1111, 4'b0100, pack4(0, 0, 20, 0)});
        run_sched(8);
        tests++; if (first_cyc !== 4 || pulses !== 1) begin fails++; $display("FAIL abort_fresh_latency: got cyc %0d pulses %0d want 4/1", first_cyc, pulses); end
        tests++; if (cap_match !== 1'b1 || cap_idx !== 6'd20 || cap_timeout !== 1'b0) begin
            fails++; $display("FAIL abort_fresh_result: got m%b idx%0d t%b want 1/20/0", cap_match, cap_idx, cap_timeout);
        end
    endtask

    initial begin
        reset         = 1'b1;
        input_valid   = 1'b0;
        str_last_idx  = '0;
        pat_last_idx  = '0;
        i_match_valid = '0;
        i_match       = '0;
        i_match_idx   = '0;
        test_reset();
        test_dispatch();
        test_out_of_order();
        test_short_string();
        test_duplicates();
        test_timeout();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
